// File: rtl/npc_btb_if.sv
// rtl/npc_btb_if.sv - resolve/redirect bus between decode and the next-PC unit
// Purpose: carries one resolved control-transfer report from decode per cycle
//   and returns the mispredict flush.
// Signals: res_valid, res_sel[2:0], res_pc[31:0], res_zero, res_imm[25:0],
//   res_rs[31:0], res_pred_taken, res_pred_target[31:0] (decode -> npc);
//   flush (npc -> decode).
// Modports: master = decode side, slave = next-PC unit.
interface npc_btb_if;
  logic        res_valid;
  logic [2:0]  res_sel;
  logic [31:0] res_pc;
  logic        res_zero;
  logic [25:0] res_imm;
  logic [31:0] res_rs;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        flush;

  modport master (
    output res_valid, res_sel, res_pc, res_zero, res_imm, res_rs,
           res_pred_taken, res_pred_target,
    input  flush
  );

  modport slave (
    input  res_valid, res_sel, res_pc, res_zero, res_imm, res_rs,
           res_pred_taken, res_pred_target,
    output flush
  );
endinterface

// File: rtl/npc_btb.sv
// rtl/npc_btb.sv - fetch-side next-PC unit with direct-mapped 2-bit BTB
// Purpose: owns the fetch PC, predicts the next PC from a BTB, resolves
//   R/BEQ/J/JR/BNE reports from decode, redirects on mispredict and trains.
// Ports: clk, reset_n (async active-low), stall (hold PC), pc, pc_4,
//   pred_taken, pred_target (fetch outputs), res (npc_btb_if.slave: resolve
//   inputs and flush output).
// Macro: NPC_BTB_EN enables BTB storage; when undefined nothing is predicted
//   taken and every taken transfer redirects.
module npc_btb #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BTB_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  npc_btb_if.slave    res
);

  logic [31:0] pc_q, pc_d;

  logic        is_beq, is_bne, is_j, is_jr;
  logic [31:0] res_pc_4, br_target, j_target;
  logic [31:0] act_target, act_next;
  logic        act_taken, mispredict;

  assign pc   = pc_q;
  assign pc_4 = pc_q + 32'd4;

  // Undefined select codes fall through as R-type (no control transfer).
  always_comb begin
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j   = 1'b0;
    is_jr  = 1'b0;
    case (res.res_sel)
      3'b001:  is_beq = 1'b1;
      3'b010:  is_j   = 1'b1;
      3'b011:  is_jr  = 1'b1;
      3'b100:  is_bne = 1'b1;
      default: ;
    endcase
  end

  assign res_pc_4  = res.res_pc + 32'd4;
  assign br_target = res_pc_4 + {{14{res.res_imm[15]}}, res.res_imm[15:0], 2'b00};
  assign j_target  = {res.res_pc[31:28], res.res_imm, 2'b00};

  assign act_taken  = is_j | is_jr | (is_beq & res.res_zero) | (is_bne & ~res.res_zero);
  assign act_target = is_jr ? res.res_rs : (is_j ? j_target : br_target);
  assign act_next   = act_taken ? act_target : res_pc_4;

  // The predicted target only matters when the transfer was actually taken.
  assign mispredict = res.res_valid &&
                      ((res.res_pred_taken != act_taken) ||
                       (act_taken && (res.res_pred_target != act_target)));
  assign res.flush  = mispredict;

  // Redirect wins over stall: the fetched stream is wrong anyway.
  always_comb begin
    pc_d = pc_q;
    if (mispredict)  pc_d = act_next;
    else if (!stall) pc_d = pred_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

`ifdef NPC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [BTB_DEPTH];
  logic             valid_d [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
  logic [TAG_W-1:0] tag_d   [BTB_DEPTH];
  logic [31:0]      tgt_q   [BTB_DEPTH];
  logic [31:0]      tgt_d   [BTB_DEPTH];
  logic [1:0]       ctr_q   [BTB_DEPTH];
  logic [1:0]       ctr_d   [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, is_jump, is_r;

  // Lookup reads registered state only, so a same-cycle update is not seen.
  assign lk_idx      = pc_q[IDX_W+1:2];
  assign lk_tag      = pc_q[31:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : pc_4;

  assign up_idx  = res.res_pc[IDX_W+1:2];
  assign up_tag  = res.res_pc[31:IDX_W+2];
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign is_jump = is_j | is_jr;
  assign is_r    = ~(is_beq | is_bne | is_j | is_jr);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (res.res_valid) begin
      if (act_taken) begin
        tgt_d[up_idx] = act_target;
        if (!up_hit) begin
          valid_d[up_idx] = 1'b1;
          tag_d[up_idx]   = up_tag;
          ctr_d[up_idx]   = is_jump ? 2'b11 : 2'b10;
        end else if (is_jump || ctr_q[up_idx] == 2'b11) begin
          ctr_d[up_idx] = 2'b11;
        end else begin
          ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
        end
      end else if (up_hit) begin
        // An R-type hit means the entry aliases a non-branch: drop it.
        if (is_r)                           valid_d[up_idx] = 1'b0;
        else if (ctr_q[up_idx] != 2'b00)    ctr_d[up_idx]   = ctr_q[up_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b00;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_4;
`endif

endmodule

// File: tb/tb_npc_btb.sv
// tb/tb_npc_btb.sv - scoreboard bench for npc_btb
`timescale 1ns/100ps
module tb_npc_btb;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc, pc_4, pred_target;
  logic        pred_taken;

  npc_btb_if res_if();

  npc_btb #(.RESET_PC(RESET_PC), .BTB_DEPTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .pc          (pc),
    .pc_4        (pc_4),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .res         (res_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_last_pt;
  logic [31:0] m_last_ptg;
`ifdef NPC_BTB_EN
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  logic [1:0]  m_ctr   [16];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = RESET_PC;
`ifdef NPC_BTB_EN
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 2'b00;
    end
`endif
  endtask

  task automatic step(input logic st, input logic rv, input logic [2:0] sel,
                      input logic [31:0] rpc, input logic z, input logic [25:0] imm,
                      input logic [31:0] rs, input logic rpt, input logic [31:0] rptg);
    logic        e_pt, tk, e_mis;
    logic [31:0] e_ptg, tg, e_next, nxt;
    logic [15:0] imm16;
    stall                  = st;
    res_if.res_valid       = rv;
    res_if.res_sel         = sel;
    res_if.res_pc          = rpc;
    res_if.res_zero        = z;
    res_if.res_imm         = imm;
    res_if.res_rs          = rs;
    res_if.res_pred_taken  = rpt;
    res_if.res_pred_target = rptg;
    @(negedge clk);
    e_pt  = 1'b0;
    e_ptg = m_pc + 32'd4;
`ifdef NPC_BTB_EN
    if (m_valid[m_pc[5:2]] && m_tag[m_pc[5:2]] == m_pc[31:6] && m_ctr[m_pc[5:2]] >= 2'd2) begin
      e_pt  = 1'b1;
      e_ptg = m_tgt[m_pc[5:2]];
    end
`endif
    imm16 = imm[15:0];
    tk = 1'b0;
    tg = rpc + 32'd4 + 32'(int'($signed(imm16)) * 4);
    case (sel)
      3'd1: tk = z;
      3'd2: begin tk = 1'b1; tg = {rpc[31:28], imm, 2'b00}; end
      3'd3: begin tk = 1'b1; tg = rs; end
      3'd4: tk = !z;
      default: tk = 1'b0;
    endcase
    e_next = tk ? tg : rpc + 32'd4;
    e_mis  = rv && ((rpt != tk) || (tk && rptg != tg));
    check("pc", pc, m_pc);
    check("pc_4", pc_4, m_pc + 32'd4);
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
    check("pred_target", pred_target, e_ptg);
    check("flush", {31'd0, res_if.flush}, {31'd0, e_mis});
    m_last_pt  = e_pt;
    m_last_ptg = e_ptg;
    nxt = e_mis ? e_next : (st ? m_pc : e_ptg);
    exp_q.push_back(nxt);
`ifdef NPC_BTB_EN
    if (rv) begin
      if (tk) begin
        if (!(m_valid[rpc[5:2]] && m_tag[rpc[5:2]] == rpc[31:6])) begin
          m_valid[rpc[5:2]] = 1'b1;
          m_tag[rpc[5:2]]   = rpc[31:6];
          m_ctr[rpc[5:2]]   = (sel == 3'd2 || sel == 3'd3) ? 2'd3 : 2'd2;
        end else begin
          m_ctr[rpc[5:2]] = (sel == 3'd2 || sel == 3'd3 || m_ctr[rpc[5:2]] == 2'd3) ?
                            2'd3 : m_ctr[rpc[5:2]] + 2'd1;
        end
        m_tgt[rpc[5:2]] = tg;
      end else if (m_valid[rpc[5:2]] && m_tag[rpc[5:2]] == rpc[31:6]) begin
        if (sel == 3'd0 || sel > 3'd4)      m_valid[rpc[5:2]] = 1'b0;
        else if (m_ctr[rpc[5:2]] != 2'd0)   m_ctr[rpc[5:2]]   = m_ctr[rpc[5:2]] - 2'd1;
      end
    end
`endif
    @(posedge clk);
    #1;
    check("pc_next", pc, exp_q.pop_front());
    m_pc = nxt;
  endtask

  task automatic idle(input logic st);
    step(st, 1'b0, 3'd0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic        r_st, r_rv, r_z, r_pt;
    logic [2:0]  r_sel;
    logic [31:0] r_pc, r_rs, r_ptg;
    logic [25:0] r_imm;
    res_if.res_valid = 1'b0; res_if.res_sel = 3'd0; res_if.res_pc = '0;
    res_if.res_zero = 1'b0; res_if.res_imm = '0; res_if.res_rs = '0;
    res_if.res_pred_taken = 1'b0; res_if.res_pred_target = '0;
    m_reset();
    #12;
    check("rst_pc", pc, RESET_PC);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, RESET_PC + 32'd4);
    check("rst_flush", {31'd0, res_if.flush}, 32'd0);
    #4 reset_n = 1'b1;

    idle(1'b0); idle(1'b0);
    idle(1'b1); idle(1'b1);
    idle(1'b0); idle(1'b0);

    // BEQ taken from 0x3010 -> 0x3020, then JR back to 0x3010 and refetch.
    step(1'b0, 1'b1, 3'd1, 32'h3010, 1'b1, 26'h0003, 32'd0, 1'b0, 32'h3014);
    step(1'b0, 1'b1, 3'd3, 32'h3020, 1'b0, 26'd0, 32'h3010, 1'b0, 32'h3024);
    idle(1'b0);
    step(1'b0, 1'b1, 3'd1, 32'h3010, 1'b0, 26'h0003, 32'd0, m_last_pt, m_last_ptg);
    step(1'b0, 1'b1, 3'd3, 32'h3030, 1'b0, 26'd0, 32'h3010, 1'b0, 32'h3034);
    idle(1'b0);

    // JR under stall, J target, BNE back, assorted prediction cases.
    step(1'b1, 1'b1, 3'd3, 32'h3100, 1'b0, 26'd0, 32'h4000, 1'b0, 32'h3104);
    step(1'b0, 1'b1, 3'd2, 32'h3000, 1'b0, 26'h0000C10, 32'd0, 1'b0, 32'h3004);
    step(1'b0, 1'b1, 3'd4, 32'h3040, 1'b0, 26'h000FFFE, 32'd0, 1'b0, 32'h3044);
    step(1'b0, 1'b1, 3'd4, 32'h3040, 1'b1, 26'h000FFFE, 32'd0, 1'b0, 32'h3044);
    step(1'b0, 1'b1, 3'd1, 32'h3050, 1'b0, 26'h0010, 32'd0, 1'b1, 32'h1234);
    step(1'b0, 1'b1, 3'd1, 32'h3050, 1'b1, 26'h0010, 32'd0, 1'b1, 32'h3094);
    step(1'b0, 1'b1, 3'd2, 32'h3060, 1'b0, 26'h0000C00, 32'd0, 1'b1, 32'h3004);
    step(1'b0, 1'b1, 3'd0, 32'h3070, 1'b0, 26'd0, 32'd0, 1'b0, 32'h3074);
    step(1'b1, 1'b1, 3'd7, 32'h3070, 1'b0, 26'd0, 32'd0, 1'b1, 32'h3074);

    for (int k = 0; k < 40; k++) begin
      r_st  = 1'($urandom_range(0, 1));
      r_rv  = 1'($urandom_range(0, 1));
      r_sel = 3'($urandom_range(0, 7));
      r_pc  = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
      r_z   = 1'($urandom_range(0, 1));
      r_imm = 26'($urandom);
      r_rs  = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
      r_pt  = 1'($urandom_range(0, 1));
      r_ptg = r_pt ? r_rs : r_pc + 32'd4;
      step(r_st, r_rv, r_sel, r_pc, r_z, r_imm, r_rs, r_pt, r_ptg);
    end

    // Asynchronous reset pulse away from any clock edge.
    #2 reset_n = 1'b0;
    #0.5;
    check("async_rst_pc", pc, RESET_PC);
    check("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("async_rst_pred_target", pred_target, RESET_PC + 32'd4);
    #0.5 reset_n = 1'b1;
    m_reset();
    idle(1'b0);
    step(1'b0, 1'b1, 3'd3, 32'h3020, 1'b0, 26'd0, 32'h3010, 1'b0, 32'h3024);
    idle(1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
